// File: rtl/loadable_down_counter_pkg.sv
// rtl/loadable_down_counter_pkg.sv - state encodings and default sizes for loadable_down_counter
package loadable_down_counter_pkg;

    localparam int STATE_W   = 2;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_MOD   = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'b00,
        ST_COUNT   = 2'b01,
        ST_EXPIRED = 2'b10
    } state_t;

endpackage

// File: rtl/loadable_down_counter.sv
// rtl/loadable_down_counter.sv - loadable MOD-N down counter with tc pulse and sticky done
// Optional auto-reload in COUNT when DOWN_COUNTER_RELOAD_EN is defined.
module loadable_down_counter
    import loadable_down_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MOD   = DEF_MOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             en,
    input  logic             ack,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] load_eff;
    logic             tc_nxt;
`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
`endif

    // Out-of-range loads saturate at the top of the legal count range.
    assign load_eff = (load_value > MAX_VAL) ? MAX_VAL : load_value;

    always_comb begin
        state_nxt  = state;
        q_nxt      = q;
        tc_nxt     = 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
        reload_nxt = reload;
`endif
        case (state)
            ST_IDLE: begin
                if (load_valid) begin
`ifdef DOWN_COUNTER_RELOAD_EN
                    reload_nxt = load_eff;
`endif
                    if (load_eff == '0) begin
                        q_nxt     = '0;
                        tc_nxt    = 1'b1;
                        state_nxt = ST_EXPIRED;
                    end else begin
                        q_nxt     = load_eff;
                        state_nxt = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                if (en) begin
                    if (q > ONE) begin
                        q_nxt = q - ONE;
                    end else if (q == ONE) begin
                        q_nxt  = '0;
                        tc_nxt = 1'b1;
`ifndef DOWN_COUNTER_RELOAD_EN
                        state_nxt = ST_EXPIRED;
`endif
                    end
`ifdef DOWN_COUNTER_RELOAD_EN
                    else begin
                        q_nxt = reload;
                    end
`endif
                end
            end
            ST_EXPIRED: begin
                if (ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            q          <= '0;
            tc         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            q          <= q_nxt;
            tc         <= tc_nxt;
            busy       <= (state_nxt == ST_COUNT);
            done       <= (state_nxt == ST_EXPIRED);
            load_ready <= (state_nxt == ST_IDLE);
`ifdef DOWN_COUNTER_RELOAD_EN
            reload     <= reload_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_loadable_down_counter.sv
// tb/tb_loadable_down_counter.sv - self-checking bench for loadable_down_counter (MOD=16 and MOD=10 instances)
module tb_loadable_down_counter;

`ifdef DOWN_COUNTER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic [3:0] load_value;
    logic       en;
    logic       ack;

    logic [3:0] q_a, q_b;
    logic       lr_a, busy_a, tc_a, done_a;
    logic       lr_b, busy_b, tc_b, done_b;

    always #5 clk = ~clk;

    loadable_down_counter #(.WIDTH(4), .MOD(16)) dut_a (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_value(load_value),
        .load_ready(lr_a), .en(en), .ack(ack), .q(q_a), .busy(busy_a), .tc(tc_a), .done(done_a)
    );

    loadable_down_counter #(.WIDTH(4), .MOD(10)) dut_b (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_value(load_value),
        .load_ready(lr_b), .en(en), .ack(ack), .q(q_b), .busy(busy_b), .tc(tc_b), .done(done_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = waiting for a load, 1 = counting, 2 = expired.
    int m_q[2];
    int m_tc[2];
    int m_rl[2];
    int m_ph[2];

    typedef struct {
        logic       lv;
        logic [3:0] val;
        logic       en;
        logic       ack;
        int         q;
        int         tc;
        int         busy;
        int         done;
        int         rdy;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_q[k]  = 0;
        m_tc[k] = 0;
        m_rl[k] = 0;
        m_ph[k] = 0;
    endtask

    task automatic model_step(input int k);
        int lim;
        int l;
        lim = (k == 0) ? 15 : 9;
        m_tc[k] = 0;
        case (m_ph[k])
            0: if (load_valid) begin
                l = (int'(load_value) > lim) ? lim : int'(load_value);
                m_rl[k] = l;
                m_q[k]  = l;
                if (l == 0) begin
                    m_tc[k] = 1;
                    m_ph[k] = 2;
                end else begin
                    m_ph[k] = 1;
                end
            end
            1: if (en) begin
                if (m_q[k] == 0) begin
                    m_q[k] = m_rl[k];
                end else begin
                    m_q[k] = m_q[k] - 1;
                    if (m_q[k] == 0) begin
                        m_tc[k] = 1;
                        if (!RELOAD) m_ph[k] = 2;
                    end
                end
            end
            default: if (ack) m_ph[k] = 0;
        endcase
    endtask

    task automatic check_model();
        chk("a.q", q_a, m_q[0]);
        chk("a.tc", tc_a, m_tc[0]);
        chk("a.busy", busy_a, int'(m_ph[0] == 1));
        chk("a.done", done_a, int'(m_ph[0] == 2));
        chk("a.ready", lr_a, int'(m_ph[0] == 0));
        chk("b.q", q_b, m_q[1]);
        chk("b.tc", tc_b, m_tc[1]);
        chk("b.busy", busy_b, int'(m_ph[1] == 1));
        chk("b.done", done_b, int'(m_ph[1] == 2));
        chk("b.ready", lr_b, int'(m_ph[1] == 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) model_reset(k);
            else model_step(k);
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic set_in(input logic lv, input logic [3:0] val, input logic e, input logic a);
        load_valid = lv;
        load_value = val;
        en         = e;
        ack        = a;
    endtask

    // Called at a negedge: reset hits between edges and must act without a clock.
    task automatic reset_async();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) model_reset(k);
        check_model();
    endtask

    task automatic reset_cycle();
        reset_async();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 4'd3,  1'b0, 1'b0, 3,  0, 1, 0, 0};
        tbl[1]  = '{1'b1, 4'd7,  1'b1, 1'b0, 2,  0, 1, 0, 0};
        tbl[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 1,  0, 1, 0, 0};
        tbl[3]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1,  0, 1, 0, 0};
        tbl[4]  = '{1'b0, 4'd0,  1'b1, 1'b0, 0,  1, 0, 1, 0};
        tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 0,  0, 0, 1, 0};
        tbl[6]  = '{1'b1, 4'd5,  1'b0, 1'b1, 0,  0, 0, 0, 1};
        tbl[7]  = '{1'b1, 4'd0,  1'b0, 1'b0, 0,  1, 0, 1, 0};
        tbl[8]  = '{1'b0, 4'd0,  1'b0, 1'b1, 0,  0, 0, 0, 1};
        tbl[9]  = '{1'b1, 4'd15, 1'b1, 1'b0, 15, 0, 1, 0, 0};
        tbl[10] = '{1'b0, 4'd0,  1'b0, 1'b1, 15, 0, 1, 0, 0};

        set_in(1'b0, 4'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) model_reset(k);
        check_model();
        @(negedge clk);
        cycle();
        reset = 1'b0;

`ifndef DOWN_COUNTER_RELOAD_EN
        for (int i = 0; i < 11; i++) begin
            set_in(tbl[i].lv, tbl[i].val, tbl[i].en, tbl[i].ack);
            cycle();
            chk($sformatf("tbl%0d.q", i), q_a, tbl[i].q);
            chk($sformatf("tbl%0d.tc", i), tc_a, tbl[i].tc);
            chk($sformatf("tbl%0d.busy", i), busy_a, tbl[i].busy);
            chk($sformatf("tbl%0d.done", i), done_a, tbl[i].done);
            chk($sformatf("tbl%0d.ready", i), lr_a, tbl[i].rdy);
        end
`endif

        // Reset mid-count.
        reset_cycle();
        set_in(1'b1, 4'd9, 1'b1, 1'b0);
        cycle();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("rst.q_before", q_a, 6);
        reset_async();
        chk("rst.q", q_a, 0);
        chk("rst.busy", busy_a, 0);
        chk("rst.tc", tc_a, 0);
        chk("rst.ready", lr_a, 1);
        cycle();
        reset = 1'b0;

`ifndef DOWN_COUNTER_RELOAD_EN
        // Full count from 15.
        set_in(1'b1, 4'd15, 1'b1, 1'b0);
        cycle();
        chk("full.q_load", q_a, 15);
        load_valid = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cycle();
            chk($sformatf("full.q%0d", i), q_a, 15 - i);
            chk($sformatf("full.tc%0d", i), tc_a, int'(i == 15));
            chk($sformatf("full.done%0d", i), done_a, int'(i == 15));
        end
        cycle();
        chk("full.tc_after", tc_a, 0);
        chk("full.done_held", done_a, 1);
        ack = 1'b1;
        cycle();
        chk("full.ack_ready", lr_a, 1);
        chk("full.ack_done", done_a, 0);
        ack = 1'b0;
`else
        // Auto-reload: load 3, twelve enabled cycles, three tc pulses.
        begin
            int pulses;
            pulses = 0;
            set_in(1'b1, 4'd3, 1'b1, 1'b0);
            cycle();
            load_valid = 1'b0;
            for (int i = 1; i <= 12; i++) begin
                cycle();
                chk($sformatf("rl.q%0d", i), q_a, ((3 - i) % 4 + 4) % 4);
                chk($sformatf("rl.done%0d", i), done_a, 0);
                if (tc_a) pulses++;
            end
            chk("rl.pulses", pulses, 3);
        end
`endif

        // Clamp on the MOD=10 instance with enable gaps.
        reset_cycle();
        set_in(1'b1, 4'd13, 1'b0, 1'b0);
        cycle();
        chk("clamp.q_load", q_b, 9);
        load_valid = 1'b0;
        begin
            int  ens;
            bit  seen;
            ens  = 0;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                en = (i % 2 == 0);
                cycle();
                if (en) ens++;
                chk("clamp.q", q_b, 9 - ens);
                if (tc_b) begin
                    seen = 1'b1;
                    chk("clamp.tc_at", ens, 9);
                end
            end
            chk("clamp.tc_seen", seen, 1);
        end

        // Randomized traffic against the model, with occasional async resets.
        reset_cycle();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                reset_cycle();
            end
            load_valid = ($urandom_range(0, 1) == 1);
            load_value = 4'($urandom);
            en         = ($urandom_range(0, 9) < 7);
            ack        = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
